// File: rtl/ks28_sum_pipe_if.sv
// Stream bundle for the Kogge-Stone sum stage: prefix-tree input side and registered result side.
// Optional out_zero signal exists only when KS_SUM_ZFLAG_EN is defined.
interface ks28_sum_pipe_if #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_hp;
  logic [WIDTH-1:0] in_gg;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;
`ifdef KS_SUM_ZFLAG_EN
  logic             out_zero;
`endif

  // Driver of the prefix-tree results and consumer of the sums.
  modport master (
    output in_valid, in_hp, in_gg, in_cin, in_tag, out_ready,
`ifdef KS_SUM_ZFLAG_EN
    input  out_zero,
`endif
    input  in_ready, out_valid, out_sum, out_cout, out_tag
  );

  modport slave (
    input  in_valid, in_hp, in_gg, in_cin, in_tag, out_ready,
`ifdef KS_SUM_ZFLAG_EN
    output out_zero,
`endif
    output in_ready, out_valid, out_sum, out_cout, out_tag
  );
endinterface

// File: rtl/ks28_sum_pipe.sv
// Final sum stage of the 28-bit Kogge-Stone adder with a 2-entry skid buffer on the output.
// Define KS_SUM_ZFLAG_EN to add a registered zero flag (out_zero) carried with each entry.
module ks28_sum_pipe #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  ks28_sum_pipe_if.slave bus
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_new;
  logic             cout_new;

  logic [WIDTH-1:0] m_sum_q, s_sum_q;
  logic             m_cout_q, s_cout_q;
  logic [TAG_W-1:0] m_tag_q, s_tag_q;
`ifdef KS_SUM_ZFLAG_EN
  logic             zero_new;
  logic             m_zero_q, s_zero_q;
`endif

  logic accept, deliver;
  logic load_m_in, load_m_s, load_s;

  // Carries are already resolved by the prefix tree; bit i takes the carry out of bit i-1.
  assign carry    = {bus.in_gg[WIDTH-2:0], bus.in_cin};
  assign sum_new  = bus.in_hp ^ carry;
  assign cout_new = bus.in_gg[WIDTH-1];
`ifdef KS_SUM_ZFLAG_EN
  assign zero_new = ~|sum_new;
`endif

  assign accept  = bus.in_valid & in_ready_q;
  assign deliver = (state_q != StEmpty) & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          load_m_in = 1'b1;
          state_d   = StOne;
        end
      end
      StOne: begin
        if (accept && deliver) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          load_s  = 1'b1;
          state_d = StTwo;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only the drain of S into M can happen.
        if (deliver) begin
          load_m_s = 1'b1;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StTwo);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum_q  <= '0;
      m_cout_q <= 1'b0;
      m_tag_q  <= '0;
    end else if (load_m_in) begin
      m_sum_q  <= sum_new;
      m_cout_q <= cout_new;
      m_tag_q  <= bus.in_tag;
    end else if (load_m_s) begin
      m_sum_q  <= s_sum_q;
      m_cout_q <= s_cout_q;
      m_tag_q  <= s_tag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sum_q  <= '0;
      s_cout_q <= 1'b0;
      s_tag_q  <= '0;
    end else if (load_s) begin
      s_sum_q  <= sum_new;
      s_cout_q <= cout_new;
      s_tag_q  <= bus.in_tag;
    end
  end

`ifdef KS_SUM_ZFLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_zero_q <= 1'b0;
      s_zero_q <= 1'b0;
    end else begin
      if (load_m_in) begin
        m_zero_q <= zero_new;
      end else if (load_m_s) begin
        m_zero_q <= s_zero_q;
      end
      if (load_s) begin
        s_zero_q <= zero_new;
      end
    end
  end

  assign bus.out_zero = m_zero_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_sum   = m_sum_q;
  assign bus.out_cout  = m_cout_q;
  assign bus.out_tag   = m_tag_q;

endmodule
